// File: rtl/otter_ex_unit_if.sv
// Execute-stage bus for otter_ex_unit: operands, control, compare flags and targets.
// Optional FUNCT3/BR_TAKEN pair exists only when EXU_BR_TAKEN_EN is defined.
interface otter_ex_unit_if;
  localparam int unsigned XLEN = 32;

  logic            EN;
  logic [XLEN-1:0] SRC_A;
  logic [XLEN-1:0] SRC_B;
  logic [3:0]      ALU_FUN;
  logic [XLEN-1:0] RS1;
  logic [XLEN-1:0] RS2;
  logic [XLEN-1:0] FROM_PC;
  logic [XLEN-1:0] I_TYPE;
  logic [XLEN-1:0] J_TYPE;
  logic [XLEN-1:0] B_TYPE;
  logic [XLEN-1:0] RESULT;
  logic [XLEN-1:0] RESULT_Q;
  logic            BR_EQ;
  logic            BR_LT;
  logic            BR_LTU;
  logic [XLEN-1:0] JAL;
  logic [XLEN-1:0] JALR;
  logic [XLEN-1:0] BRANCH;
`ifdef EXU_BR_TAKEN_EN
  logic [2:0]      FUNCT3;
  logic            BR_TAKEN;

  modport master (
    output EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE, FUNCT3,
    input  RESULT, RESULT_Q, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH, BR_TAKEN
  );
  modport slave (
    input  EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE, FUNCT3,
    output RESULT, RESULT_Q, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH, BR_TAKEN
  );
`else
  modport master (
    output EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE,
    input  RESULT, RESULT_Q, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH
  );
  modport slave (
    input  EN, SRC_A, SRC_B, ALU_FUN, RS1, RS2, FROM_PC, I_TYPE, J_TYPE, B_TYPE,
    output RESULT, RESULT_Q, BR_EQ, BR_LT, BR_LTU, JAL, JALR, BRANCH
  );
`endif
endinterface

// File: rtl/otter_ex_unit.sv
// OTTER execute stage: ALU, branch compare and branch/jump target generation with a
// falling-edge result register. EXU_BR_TAKEN_EN adds the funct3 branch decision.
module otter_ex_unit (
  input  logic          CLK,
  input  logic          RST,
  otter_ex_unit_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned SHW  = 5;

  logic [XLEN-1:0] result;
  logic [SHW-1:0]  shamt;

  assign shamt = bus.SRC_B[SHW-1:0];

  // ALU operation decode; unused codes yield zero
  always_comb begin
    result = '0;
    unique case (bus.ALU_FUN)
      4'b0000: result = bus.SRC_A + bus.SRC_B;
      4'b1000: result = bus.SRC_A - bus.SRC_B;
      4'b0001: result = bus.SRC_A << shamt;
      4'b0010: result = XLEN'($signed(bus.SRC_A) < $signed(bus.SRC_B));
      4'b0011: result = XLEN'(bus.SRC_A < bus.SRC_B);
      4'b0100: result = bus.SRC_A ^ bus.SRC_B;
      4'b0101: result = bus.SRC_A >> shamt;
      4'b1101: result = XLEN'($signed(bus.SRC_A) >>> shamt);
      4'b0110: result = bus.SRC_A | bus.SRC_B;
      4'b0111: result = bus.SRC_A & bus.SRC_B;
      4'b1001: result = bus.SRC_A;
      default: result = '0;
    endcase
  end

  assign bus.RESULT = result;

  // Result register clocks on the falling edge, in step with the pipeline registers
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      bus.RESULT_Q <= '0;
    end else if (bus.EN) begin
      bus.RESULT_Q <= result;
    end
  end

  assign bus.BR_EQ  = (bus.RS1 == bus.RS2);
  assign bus.BR_LT  = ($signed(bus.RS1) < $signed(bus.RS2));
  assign bus.BR_LTU = (bus.RS1 < bus.RS2);

  // Targets wrap modulo 2^32; JALR clears bit 0
  assign bus.JAL    = bus.FROM_PC + bus.J_TYPE;
  assign bus.BRANCH = bus.FROM_PC + bus.B_TYPE;
  assign bus.JALR   = (bus.RS1 + bus.I_TYPE) & ~XLEN'(1);

`ifdef EXU_BR_TAKEN_EN
  always_comb begin
    bus.BR_TAKEN = 1'b0;
    unique case (bus.FUNCT3)
      3'b000:  bus.BR_TAKEN = bus.BR_EQ;
      3'b001:  bus.BR_TAKEN = ~bus.BR_EQ;
      3'b100:  bus.BR_TAKEN = bus.BR_LT;
      3'b101:  bus.BR_TAKEN = ~bus.BR_LT;
      3'b110:  bus.BR_TAKEN = bus.BR_LTU;
      3'b111:  bus.BR_TAKEN = ~bus.BR_LTU;
      default: bus.BR_TAKEN = 1'b0;
    endcase
  end
`endif
endmodule

// File: tb/tb_otter_ex_unit.sv
// Directed bench for otter_ex_unit with hand-computed expectations.
module tb_otter_ex_unit;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  otter_ex_unit_if bus ();

  otter_ex_unit dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_alu(input logic [3:0] fun, input logic [31:0] a, input logic [31:0] b);
    bus.ALU_FUN = fun;
    bus.SRC_A   = a;
    bus.SRC_B   = b;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    bus.EN = 1'b0;
    bus.SRC_A = '0;
    bus.SRC_B = '0;
    bus.ALU_FUN = 4'b0000;
    bus.RS1 = '0;
    bus.RS2 = '0;
    bus.FROM_PC = '0;
    bus.I_TYPE = '0;
    bus.J_TYPE = '0;
    bus.B_TYPE = '0;
`ifdef EXU_BR_TAKEN_EN
    bus.FUNCT3 = 3'b000;
`endif

    // asynchronous reset between clock edges
    #2 RST = 1'b0;
    #1 check("reset_async", bus.RESULT_Q, 32'h0);
    RST = 1'b1;
    bus.EN = 1'b1;
    set_alu(4'b0000, 32'd5, 32'd7);
    @(negedge CLK); #1;
    check("first_capture", bus.RESULT_Q, 32'd12);

    bus.EN = 1'b0;
    set_alu(4'b0000, 32'h8000_0000, 32'h1); check("add",  bus.RESULT, 32'h8000_0001);
    set_alu(4'b1000, 32'h8000_0000, 32'h1); check("sub",  bus.RESULT, 32'h7FFF_FFFF);
    set_alu(4'b1101, 32'h8000_0000, 32'h1); check("sra",  bus.RESULT, 32'hC000_0000);
    set_alu(4'b0101, 32'h8000_0000, 32'h1); check("srl",  bus.RESULT, 32'h4000_0000);
    set_alu(4'b0010, 32'h8000_0000, 32'h1); check("slt",  bus.RESULT, 32'h1);
    set_alu(4'b0011, 32'h8000_0000, 32'h1); check("sltu", bus.RESULT, 32'h0);
    set_alu(4'b1001, 32'h8000_0000, 32'h1); check("copy", bus.RESULT, 32'h8000_0000);
    set_alu(4'b1111, 32'h8000_0000, 32'h1); check("bad_f", bus.RESULT, 32'h0);
    set_alu(4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F04); check("sll", bus.RESULT, 32'h0F00_0FF0);
    set_alu(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F04); check("xor", bus.RESULT, 32'hFF00_0FFB);
    set_alu(4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F04); check("or",  bus.RESULT, 32'hFFF0_0FFF);
    set_alu(4'b0111, 32'hF0F0_00FF, 32'h0FF0_0F04); check("and", bus.RESULT, 32'h00F0_0004);
    set_alu(4'b1010, 32'hF0F0_00FF, 32'h0FF0_0F04); check("bad_a", bus.RESULT, 32'h0);
    set_alu(4'b0010, 32'h0000_0001, 32'h8000_0000); check("slt_pos", bus.RESULT, 32'h0);
    set_alu(4'b0011, 32'h0000_0001, 32'h8000_0000); check("sltu_pos", bus.RESULT, 32'h1);

    // compare flags
    bus.RS1 = 32'hFFFF_FFFF; bus.RS2 = 32'h1; #1;
    check("eq_ne",  32'(bus.BR_EQ),  32'd0);
    check("lt_neg", 32'(bus.BR_LT),  32'd1);
    check("ltu_big", 32'(bus.BR_LTU), 32'd0);
    bus.RS1 = 32'd3; bus.RS2 = 32'd3; #1;
    check("eq_eq",  32'(bus.BR_EQ),  32'd1);
    check("lt_eq",  32'(bus.BR_LT),  32'd0);
    check("ltu_eq", 32'(bus.BR_LTU), 32'd0);
`ifdef EXU_BR_TAKEN_EN
    bus.FUNCT3 = 3'b000; #1; check("taken_beq", 32'(bus.BR_TAKEN), 32'd1);
    bus.FUNCT3 = 3'b001; #1; check("taken_bne", 32'(bus.BR_TAKEN), 32'd0);
    bus.FUNCT3 = 3'b010; #1; check("taken_010", 32'(bus.BR_TAKEN), 32'd0);
    bus.FUNCT3 = 3'b101; #1; check("taken_bge", 32'(bus.BR_TAKEN), 32'd1);
`endif

    // branch/jump targets
    bus.FROM_PC = 32'h100; bus.J_TYPE = 32'hFFFF_FFF0; bus.B_TYPE = 32'd8;
    bus.RS1 = 32'h201; bus.I_TYPE = 32'd2; #1;
    check("jal",    bus.JAL,    32'h0000_00F0);
    check("branch", bus.BRANCH, 32'h0000_0108);
    check("jalr",   bus.JALR,   32'h0000_0202);
    bus.FROM_PC = 32'hFFFF_FFFC; bus.B_TYPE = 32'd8; bus.RS1 = 32'h0; bus.I_TYPE = 32'h7; #1;
    check("branch_wrap", bus.BRANCH, 32'h0000_0004);
    check("jalr_bit0",   bus.JALR,   32'h0000_0006);

    // stall holds across two falling edges, then loads
    bus.EN = 1'b0;
    set_alu(4'b0000, 32'd1, 32'd1);
    @(negedge CLK); #1;
    set_alu(4'b0000, 32'd2, 32'd2);
    @(negedge CLK); #1;
    check("stall_hold", bus.RESULT_Q, 32'd12);
    bus.EN = 1'b1;
    @(negedge CLK); #1;
    check("stall_release", bus.RESULT_Q, 32'd4);

    // reset during a stall discards the held value
    bus.EN = 1'b0;
    RST = 1'b0; #1;
    check("reset_stall", bus.RESULT_Q, 32'h0);
    RST = 1'b1;
    @(negedge CLK); #1;
    check("reset_stall_hold", bus.RESULT_Q, 32'h0);
    bus.EN = 1'b1;
    set_alu(4'b1000, 32'd10, 32'd3);
    @(negedge CLK); #1;
    check("after_reset_load", bus.RESULT_Q, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
